i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target (slave) responder with an internal byte register file. It is the far end of the bus driven by `bus_sequencer_top` in I2C mode. It acts as the on-chip bus model in sequencer benches and as a loop-back target in hardware bring-up. It oversamples SCL/SDA on the system clock and decodes START/STOP, address, register pointer and data. It ACKs writes and serves reads with an auto-incrementing pointer.

## Interface
Parameters:
- `TARGET_ADDR`, 7'h50, 7-bit I2C address the block responds to.
- `REG_DEPTH`, 16, number of 8-bit registers; power of two, 2..256.
- `SYNC_STAGES`, 2, synchroniser flops on `i2c_scl_i`/`i2c_sda_i`; minimum 2.

Ports:
- `clk_i` in 1: system clock; must be ≥ 20× SCL frequency.
- `rst_i` in 1: synchronous, active-high reset.
- `i2c_scl_i` in 1: SCL pad input; the block never drives SCL.
- `i2c_sda_i` in 1: SDA pad input.
- `i2c_sda_o` out 1: SDA output value; constant 0 (open-drain).
- `i2c_sda_t` out 1: SDA tristate control; 1 = released, 0 = pull low.
- `busy_o` out 1: high from START until STOP.
- `wr_valid_o` out 1: one-cycle pulse per register written.
- `wr_addr_o` out 8: register index of the write; upper bits are 0 when `REG_DEPTH` < 256.
- `wr_data_o` out 8: data byte written.

## Operation
- Input conditioning: `SYNC_STAGES` synchroniser, then one edge-detect flop per line, giving `scl_rise`, `scl_fall`, `start` and `stop`.
  - `start`: SDA falls while SCL is high.
  - `stop`: SDA rises while SCL is high.
- SDA is sampled on `scl_rise`. SDA drive changes only on `scl_fall`.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Transitions:
  - START from any state → ADDR, bit counter cleared. This also covers repeated START.
  - STOP from any state → IDLE; SDA released.
  - ADDR: shift in 8 bits MSB-first.
    - Address match + R/W=0 → ADDR_ACK → PTR.
    - Address match + R/W=1 → ADDR_ACK → RDATA.
    - Mismatch → IGNORE: SDA released, stay until START/STOP.
  - PTR: 8 bits in. Pointer ← byte mod `REG_DEPTH`. ACK, then → WDATA.
  - WDATA: 8 bits in. On the 8th `scl_rise`: register[ptr] ← byte, `wr_valid_o` pulses, pointer increments. ACK, then → WDATA.
  - RDATA: on `scl_fall`, drive register[ptr] MSB-first; `sda_t=0` for 0 bits, 1 for 1 bits. After 8 bits release SDA → RDATA_ACK.
  - RDATA_ACK: sample the controller's bit.
    - ACK (0): pointer increments → RDATA.
    - NACK (1): → IGNORE.
- ACK drive: `sda_t=0` from the `scl_fall` after bit 8 until the `scl_fall` after the ACK clock.
- Pointer wraps from `REG_DEPTH-1` to 0 on both reads and writes.
- The pointer persists across transactions. A read without a preceding pointer write starts at the last pointer.
- Simultaneous events:
  - A write pulse and a STOP in the same cycle: the write still completes.
  - START takes priority over bit shifting.

## Timing
- Reset values:
  - `i2c_sda_t=1`, `i2c_sda_o=0`.
  - `busy_o=0`, `wr_valid_o=0`, `wr_addr_o=0`, `wr_data_o=0`.
  - All registers 0, pointer 0, FSM IDLE.
- Input latency: pad edge → internal event in `SYNC_STAGES`+1 cycles.
- SDA drive update: registered, `SYNC_STAGES`+2 cycles after the SCL falling edge at the pad.
- `wr_valid_o`: asserted `SYNC_STAGES`+2 cycles after the 8th data-bit SCL rising edge at the pad. `wr_addr_o`/`wr_data_o` are valid in the same cycle and held until the next write.
- `busy_o`: rises 1 cycle after `start`, falls 1 cycle after `stop`.
- Reset mid-transfer: SDA released on the next clock. Registers and pointer are cleared. The block stays IDLE until a fresh START.

## Configuration
- Macro: `I2C_TARGET_GENERAL_CALL_EN`.
- Defined:
  - Address 7'h00 with R/W=0 is ACKed.
  - A following byte 8'h06 is ACKed; all registers and the pointer are cleared at that ACK, with no `wr_valid_o`.
  - Any other byte is NACKed → IGNORE.
  - 7'h00 with R/W=1 → IGNORE.
- Undefined: address 7'h00 is treated as a normal mismatch → IGNORE.

## Test plan
- Write burst: START, 0xA0, 0x03, 0x11, 0x22, STOP → three ACK windows plus data ACKs; `wr_valid_o` pulses with (3,0x11) then (4,0x22); `busy_o` low after STOP.
- Read with repeated START: write pointer 0x03, repeated START, 0xA1, controller ACKs then NACKs → SDA bytes 0x11, 0x22; SDA released after NACK.
- Address mismatch: START, 0xB0, 0x00, STOP → SDA never pulled low; no `wr_valid_o`.
- Wrap: pointer 0x0F, write 0xAA, 0xBB → writes to index 15 then 0; pointer 0x1F then read → returns register 15.
- Reset mid-read: assert `rst_i` during bit 4 of RDATA → `i2c_sda_t=1` next cycle; a subsequent read from pointer 0 returns 0x00.
- Macro defined: START, 0x00, 0x06, STOP → both bytes ACKed; all registers read back 0x00. Macro undefined: same stimulus → NACK on the address.

Source files
------------

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with auto-incrementing byte register file
// Optional general-call reset (address 0x00, command 0x06) under `I2C_TARGET_GENERAL_CALL_EN.
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         REG_DEPTH   = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i2c_scl_i,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o,
    output logic       i2c_sda_t,
    output logic       busy_o,
    output logic       wr_valid_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o
);
    localparam int PTR_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_ev, stop_ev;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [7:0]         shift_q, shift_d, tx_q, tx_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               sda_t_q, sda_t_d, busy_q, busy_d;
    logic               dir_q, dir_d, gc_q, gc_d, rd_ack_q, rd_ack_d;
    logic               wr_fire, clear_all;
    logic [7:0]         rx_byte, rd_byte;
    logic [7:0]         regs_q [REG_DEPTH];

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte  = {shift_q[6:0], sda_s};
    assign rd_byte  = regs_q[ptr_q];

    // Idle-high reset values keep a reset release from looking like a bus event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_t_d   = sda_t_q;
        busy_d    = busy_q;
        dir_d     = dir_q;
        gc_d      = gc_q;
        rd_ack_d  = rd_ack_q;
        wr_fire   = 1'b0;
        clear_all = 1'b0;
        if (start_ev) begin
            state_d = ADDR;
            cnt_d   = 4'd0;
            sda_t_d = 1'b1;
            busy_d  = 1'b1;
            gc_d    = 1'b0;
        end else if (stop_ev) begin
            state_d = IDLE;
            sda_t_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise && cnt_q < 4'd8) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7 && state_q == PTR && !gc_q) begin
                            ptr_d = rx_byte[PTR_W-1:0];
                        end
                        if (cnt_q == 4'd7 && state_q == WDATA) begin
                            wr_fire = 1'b1;
                            ptr_d   = ptr_q + PTR_W'(1);
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d   = 4'd0;
                        state_d = IGNORE;
                        if (state_q == ADDR) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                sda_t_d = 1'b0;
                                state_d = ADDR_ACK;
                                dir_d   = shift_q[0];
                            end
`ifdef I2C_TARGET_GENERAL_CALL_EN
                            else if (shift_q == 8'h00) begin
                                sda_t_d = 1'b0;
                                state_d = ADDR_ACK;
                                dir_d   = 1'b0;
                                gc_d    = 1'b1;
                            end
`endif
                        end else if (state_q == PTR && gc_q) begin
                            if (shift_q == 8'h06) begin
                                sda_t_d   = 1'b0;
                                state_d   = PTR_ACK;
                                clear_all = 1'b1;
                                ptr_d     = '0;
                            end
                        end else begin
                            sda_t_d = 1'b0;
                            state_d = (state_q == PTR) ? PTR_ACK : WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_rise) begin
                        cnt_d = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d   = 4'd0;
                        sda_t_d = 1'b1;
                        if (state_q == ADDR_ACK && dir_q) begin
                            state_d = RDATA;
                            tx_d    = rd_byte;
                            sda_t_d = rd_byte[7];
                        end else if (state_q == ADDR_ACK) begin
                            state_d = PTR;
                        end else if (state_q == PTR_ACK && gc_q) begin
                            state_d = IGNORE;
                        end else begin
                            state_d = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        if (cnt_q == 4'd8) begin
                            sda_t_d = 1'b1;
                            state_d = RDATA_ACK;
                            cnt_d   = 4'd0;
                        end else begin
                            sda_t_d = tx_q[6];
                            tx_d    = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        cnt_d    = 4'd1;
                        rd_ack_d = ~sda_s;
                        if (!sda_s) ptr_d = ptr_q + PTR_W'(1);
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d = 4'd0;
                        if (rd_ack_q) begin
                            state_d = RDATA;
                            tx_d    = rd_byte;
                            sda_t_d = rd_byte[7];
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            ptr_q      <= '0;
            sda_t_q    <= 1'b1;
            busy_q     <= 1'b0;
            dir_q      <= 1'b0;
            gc_q       <= 1'b0;
            rd_ack_q   <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= 8'h00;
            wr_data_o  <= 8'h00;
            for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            sda_t_q    <= sda_t_d;
            busy_q     <= busy_d;
            dir_q      <= dir_d;
            gc_q       <= gc_d;
            rd_ack_q   <= rd_ack_d;
            wr_valid_o <= wr_fire;
            if (clear_all) begin
                for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= 8'h00;
            end
            if (wr_fire) begin
                regs_q[ptr_q] <= rx_byte;
                wr_addr_o     <= 8'(ptr_q);
                wr_data_o     <= rx_byte;
            end
        end
    end

    assign i2c_sda_o = 1'b0;
    assign i2c_sda_t = sda_t_q;
    assign busy_o    = busy_q;
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed I2C controller bench for i2c_target_regs
module tb_i2c_target_regs;
    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       sda_bus;
    logic       sda_o, sda_t, busy, wr_valid;
    logic [7:0] wr_addr, wr_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] wq [$];
    logic        low_seen = 1'b0;

    assign sda_bus = sda_ctrl & (sda_t | sda_o);

    always #5 clk = ~clk;

    i2c_target_regs dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .i2c_scl_i  (scl),
        .i2c_sda_i  (sda_bus),
        .i2c_sda_o  (sda_o),
        .i2c_sda_t  (sda_t),
        .busy_o     (busy),
        .wr_valid_o (wr_valid),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data)
    );

    always @(negedge clk) begin
        if (wr_valid) wq.push_back({wr_addr, wr_data});
        if (!sda_t) low_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wq_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1; wq_wait(Q);
        scl = 1'b1;      wq_wait(Q);
        sda_ctrl = 1'b0; wq_wait(Q);
        scl = 1'b0;      wq_wait(Q);
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0; wq_wait(Q);
        scl = 1'b1;      wq_wait(Q);
        sda_ctrl = 1'b1; wq_wait(Q);
    endtask

    task automatic bit_cycle(input logic b, output logic sampled);
        sda_ctrl = b; wq_wait(Q);
        scl = 1'b1;   wq_wait(Q);
        sampled = sda_bus;
        wq_wait(Q);
        scl = 1'b0;   wq_wait(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
        bit_cycle(1'b1, nack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_cycle(1'b1, s);
            b[i] = s;
        end
        bit_cycle(nack, s);
    endtask

    logic       nk;
    logic [7:0] rb;
    logic [15:0] ent;
    logic       exp_gc_nack;
    logic [7:0] exp_r0, exp_r1;

    initial begin
        wq_wait(3);
        check("rst_sda_t", sda_t, 1);
        check("rst_sda_o", sda_o, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst = 1'b0;
        wq_wait(5);

        // write burst
        i2c_start();
        check("busy_after_start", busy, 1);
        send_byte(8'hA0, nk); check("wb_addr_ack", nk, 0);
        send_byte(8'h03, nk); check("wb_ptr_ack", nk, 0);
        send_byte(8'h11, nk); check("wb_d0_ack", nk, 0);
        send_byte(8'h22, nk); check("wb_d1_ack", nk, 0);
        i2c_stop();
        wq_wait(4);
        check("busy_after_stop", busy, 0);
        check("wb_count", wq.size(), 2);
        ent = (wq.size() > 0) ? wq.pop_front() : 16'hFFFF; check("wb_w0", ent, 16'h0311);
        ent = (wq.size() > 0) ? wq.pop_front() : 16'hFFFF; check("wb_w1", ent, 16'h0422);

        // read with repeated start
        i2c_start();
        send_byte(8'hA0, nk); check("rd_addr_ack", nk, 0);
        send_byte(8'h03, nk); check("rd_ptr_ack", nk, 0);
        i2c_start();
        send_byte(8'hA1, nk); check("rd_raddr_ack", nk, 0);
        recv_byte(1'b0, rb); check("rd_byte0", rb, 8'h11);
        recv_byte(1'b1, rb); check("rd_byte1", rb, 8'h22);
        check("rd_released_after_nack", sda_t, 1);
        i2c_stop();

        // address mismatch
        low_seen = 1'b0;
        i2c_start();
        send_byte(8'hB0, nk); check("mm_addr_nack", nk, 1);
        send_byte(8'h00, nk); check("mm_data_nack", nk, 1);
        i2c_stop();
        wq_wait(4);
        check("mm_never_low", low_seen, 0);
        check("mm_no_write", wq.size(), 0);

        // pointer wrap
        i2c_start();
        send_byte(8'hA0, nk);
        send_byte(8'h0F, nk);
        send_byte(8'hAA, nk);
        send_byte(8'hBB, nk); check("wr_wrap_ack", nk, 0);
        i2c_stop();
        wq_wait(4);
        ent = (wq.size() > 0) ? wq.pop_front() : 16'hFFFF; check("wrap_w0", ent, 16'h0FAA);
        ent = (wq.size() > 0) ? wq.pop_front() : 16'hFFFF; check("wrap_w1", ent, 16'h00BB);
        i2c_start();
        send_byte(8'hA0, nk);
        send_byte(8'h1F, nk);
        i2c_start();
        send_byte(8'hA1, nk);
        recv_byte(1'b1, rb); check("wrap_read_r15", rb, 8'hAA);
        i2c_stop();

        // reset in the middle of a read
        i2c_start();
        send_byte(8'hA0, nk);
        send_byte(8'h00, nk);
        send_byte(8'hA5, nk);
        i2c_stop();
        wq.delete();
        i2c_start();
        send_byte(8'hA0, nk);
        send_byte(8'h00, nk);
        i2c_start();
        send_byte(8'hA1, nk);
        for (int i = 0; i < 3; i++) begin
            bit_cycle(1'b1, nk);
            rb[7-i] = nk;
        end
        check("mid_read_bits", rb[7:5], 3'b101);
        check("mid_read_bit4_low", sda_t, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_read_rst_release", sda_t, 1);
        check("mid_read_rst_busy", busy, 0);
        rst = 1'b0;
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, nk); check("post_rst_addr_ack", nk, 0);
        recv_byte(1'b1, rb); check("post_rst_read", rb, 8'h00);
        i2c_stop();

        // general call
        i2c_start();
        send_byte(8'hA0, nk);
        send_byte(8'h00, nk);
        send_byte(8'h77, nk);
        send_byte(8'h66, nk);
        i2c_stop();
`ifdef I2C_TARGET_GENERAL_CALL_EN
        exp_gc_nack = 1'b0; exp_r0 = 8'h00; exp_r1 = 8'h00;
`else
        exp_gc_nack = 1'b1; exp_r0 = 8'h77; exp_r1 = 8'h66;
`endif
        i2c_start();
        send_byte(8'h00, nk); check("gc_addr", nk, exp_gc_nack);
        send_byte(8'h06, nk); check("gc_cmd", nk, exp_gc_nack);
        i2c_stop();
        wq_wait(4);
        i2c_start();
        send_byte(8'hA0, nk);
        send_byte(8'h00, nk);
        i2c_start();
        send_byte(8'hA1, nk);
        recv_byte(1'b0, rb); check("gc_read_r0", rb, exp_r0);
        recv_byte(1'b1, rb); check("gc_read_r1", rb, exp_r1);
        i2c_stop();
        check("gc_no_write_pulses", wq.size(), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
